// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - FIR filter defaults, clog2 and output reduction (FIR_FILTER_OUT_SAT_EN selects saturation)
package fir_pkg;

    localparam int DEF_NUM_TAPS = 5;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_COEF_W   = 16;
    localparam int DEF_OUT_W    = 32;

    localparam logic [DEF_NUM_TAPS*DEF_COEF_W-1:0] DEFAULT_COEFS =
        {16'd1, 16'd2, 16'd3, 16'd2, 16'd1};

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Result is sign-extended to 64 bits; callers keep the low out_w bits.
    function automatic logic signed [63:0] sat_or_wrap(input logic signed [63:0] acc,
                                                       input int out_w);
`ifdef FIR_FILTER_OUT_SAT_EN
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (acc > max_v) begin
            return max_v;
        end else if (acc < min_v) begin
            return min_v;
        end else begin
            return acc;
        end
`else
        return (acc <<< (64 - out_w)) >>> (64 - out_w);
`endif
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - NUM_TAPS-1 stage sample shift register with synchronous active-low clear
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [DATA_W-1:0]                din,
    output logic [(NUM_TAPS-1)*DATA_W-1:0]   taps
);

    logic [(NUM_TAPS-1)*DATA_W-1:0] taps_d;
    logic [(NUM_TAPS-1)*DATA_W-1:0] taps_q;

    // Slot 0 holds the most recent past sample.
    always_comb begin
        taps_d = taps_q;
        taps_d[0 +: DATA_W] = din;
        for (int k = 1; k < NUM_TAPS - 1; k++) begin
            taps_d[k*DATA_W +: DATA_W] = taps_q[(k-1)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps = taps_q;

endmodule

// File: rtl/fir_filter.sv
// rtl/fir_filter.sv - direct-form FIR with registered output; FIR_FILTER_OUT_SAT_EN clamps instead of wrapping
module fir_filter
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int COEF_W   = DEF_COEF_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter logic [NUM_TAPS*COEF_W-1:0] COEFS = DEFAULT_COEFS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] x_in,
    output logic [OUT_W-1:0]  y_out
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = OUT_W + clog2(NUM_TAPS);

    logic [(NUM_TAPS-1)*DATA_W-1:0] taps;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        acc;
    logic [OUT_W-1:0]               y_d;
    logic [OUT_W-1:0]               y_q;

    fir_delay_line #(
        .NUM_TAPS (NUM_TAPS),
        .DATA_W   (DATA_W)
    ) u_delay (
        .clk    (clk),
        .resetn (reset),
        .din    (x_in),
        .taps   (taps)
    );

    // Tap 0 multiplies the live input so the newest sample reaches y_out after one edge.
    always_comb begin
        prod = PROD_W'($signed(x_in)) * PROD_W'($signed(COEFS[0 +: COEF_W]));
        acc  = ACC_W'(prod);
        for (int k = 1; k < NUM_TAPS; k++) begin
            prod = PROD_W'($signed(taps[(k-1)*DATA_W +: DATA_W]))
                 * PROD_W'($signed(COEFS[k*COEF_W +: COEF_W]));
            acc  = acc + ACC_W'(prod);
        end
        y_d = OUT_W'(sat_or_wrap(64'(acc), OUT_W));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y_out = y_q;

endmodule

// File: tb/tb_fir_filter.sv
// tb/tb_fir_filter.sv - directed and random self-checking bench for fir_filter
module tb_fir_filter;

    localparam logic [79:0] OVF_COEFS = {5{16'h7fff}};

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [15:0]        x_in = '0;
    logic [15:0]        x_ovf = '0;
    logic signed [31:0] y_out;
    logic signed [31:0] y_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    fir_filter u_dut (
        .clk   (clk),
        .reset (reset),
        .x_in  (x_in),
        .y_out (y_out)
    );

    fir_filter #(.COEFS(OVF_COEFS)) u_ovf (
        .clk   (clk),
        .reset (reset),
        .x_in  (x_ovf),
        .y_out (y_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic signed [15:0] x, input logic rst);
        x_in  = x;
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    int imp_exp[7]  = '{1, 2, 3, 2, 1, 0, 0};
    int step_exp[6] = '{1, 3, 6, 8, 9, 9};
    int neg_exp[5]  = '{-2, -6, -12, -16, -18};
    int coef[5]     = '{1, 2, 3, 2, 1};
    int hist[5];
    longint exp_v;
    logic signed [15:0] xv;

    initial begin
        // Reset with a nonzero input that must be ignored
        tick(16'sd1234, 1'b0);
        tick(16'sd1234, 1'b0);
        check("reset_y", y_out, 64'sd0);
        check("reset_taps", 64'(u_dut.taps), 64'sd0);
        tick(16'sd0, 1'b1);
        check("release_y0", y_out, 64'sd0);
        tick(16'sd0, 1'b1);
        check("release_y1", y_out, 64'sd0);

        tick(16'sd1, 1'b1);
        check("impulse0", y_out, 64'(imp_exp[0]));
        for (int i = 1; i < 7; i++) begin
            tick(16'sd0, 1'b1);
            check($sformatf("impulse%0d", i), y_out, 64'(imp_exp[i]));
        end

        for (int i = 0; i < 6; i++) begin
            tick(16'sd1, 1'b1);
            check($sformatf("step%0d", i), y_out, 64'(step_exp[i]));
        end

        tick(16'sd1, 1'b0);
        check("midreset_y", y_out, 64'sd0);
        check("midreset_taps", 64'(u_dut.taps), 64'sd0);
        for (int i = 0; i < 5; i++) begin
            tick(16'sd1, 1'b1);
            check($sformatf("after_reset%0d", i), y_out, 64'(step_exp[i]));
        end

        tick(16'sd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(-16'sd2, 1'b1);
            check($sformatf("negstep%0d", i), y_out, 64'(neg_exp[i]));
        end

        // Overflow instance: every product is 32767 * -32768
        x_ovf = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            tick(16'sd0, 1'b1);
        end
`ifdef FIR_FILTER_OUT_SAT_EN
        check("ovf_4", y_ovf, -64'sd2147483648);
`else
        check("ovf_4", y_ovf, 64'sd131072);
`endif
        tick(16'sd0, 1'b1);
`ifdef FIR_FILTER_OUT_SAT_EN
        check("ovf_5", y_ovf, -64'sd2147483648);
`else
        check("ovf_5", y_ovf, -64'sd1073577984);
`endif
        x_ovf = '0;

        tick(16'sd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            hist[k] = 0;
        end
        for (int n = 0; n < 200; n++) begin
            xv = 16'($urandom_range(0, 65535));
            for (int k = 4; k > 0; k--) begin
                hist[k] = hist[k-1];
            end
            hist[0] = int'(xv);
            exp_v = 0;
            for (int k = 0; k < 5; k++) begin
                exp_v = exp_v + longint'(coef[k]) * longint'(hist[k]);
            end
            tick(xv, 1'b1);
            check($sformatf("rand%0d", n), y_out, exp_v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
